// File: rtl/aes_pkg.sv
// aes_pkg: shared AES inverse-cipher definitions.
//  NB              state width in 32-bit columns
//  state_t         FSM encoding {IDLE, RUN, DONE}
//  inv_sbox        inverse S-box byte lookup
//  xtime, gmul     GF(2^8) arithmetic mod x^8+x^4+x^3+x+1
//  inv_shift_rows, inv_sub_bytes, inv_mix_columns
//                  whole-state transforms on a 128-bit column-major state,
//                  where byte0 = [127:120] and byte k holds row k%4 of column k/4
package aes_pkg;

  localparam int NB = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Byte 0x00 maps from the most significant byte of this table.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; one operand is always a small constant here.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Row r is rotated right by r columns: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127 - 8 * k -: 8] = inv_sbox(s[127 - 8 * k -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES decryption round.
//  state_in   in   128  current state
//  round_key  in   128  round key added after InvSubBytes
//  last       in   1    final round: skip InvMixColumns
//  state_out  out  128  next state
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] keyed;

  assign keyed     = inv_sub_bytes(inv_shift_rows(state_in)) ^ round_key;
  assign state_out = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES inverse cipher, one round per clock.
//  clk, rst_n           clock, synchronous active-low reset
//  in_valid/in_ready    ciphertext handshake, in_data 128-bit block
//  k_sch                (Nr+1)*128 key schedule, round key i at k_sch[(Nr-i)*128 +: 128]
//  out_valid/out_ready  plaintext handshake, out_data 128-bit block
//  busy                 a block is in flight
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int Nk = 8,
  parameter int Nr = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  input  logic [(Nr+1)*128-1:0] k_sch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data,
  output logic                  busy
);

  localparam int CW = $clog2(Nr + 1);

  if (Nr != Nk + 6) begin : g_bad_param
    $error("aes_inv_cipher_iter: Nr must equal Nk + 6");
  end

  state_t        state;
  logic [CW-1:0] round_cnt;
  logic [127:0]  state_reg;
  logic [127:0]  round_key;
  logic [127:0]  round_out;
  logic          last_round;

  // round_cnt directly names the round key used in this cycle.
  assign round_key  = k_sch[(Nr - int'(round_cnt)) * 128 +: 128];
  assign last_round = (round_cnt == '0);
  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);

  aes_inv_round u_round (
    .state_in  (state_reg),
    .round_key (round_key),
    .last      (last_round),
    .state_out (round_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      round_cnt <= '0;
      state_reg <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Initial AddRoundKey with rk[Nr], the lowest 128 bits of the schedule.
            state_reg <= in_data ^ k_sch[127:0];
            round_cnt <= CW'(Nr - 1);
            state     <= RUN;
          end
        end
        RUN: begin
          if (!last_round) begin
            state_reg <= round_out;
            round_cnt <= round_cnt - 1'b1;
          end else begin
            out_data  <= round_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: directed known-answer bench for the iterative AES
// inverse cipher. Three instances cover AES-128/192/256; key schedules are
// expanded here from the cipher keys using an S-box derived from GF(2^8).
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic         in_valid  [3];
  logic         out_ready [3];
  logic [127:0] in_data   [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];

  logic [1407:0] k_sch_128;
  logic [1663:0] k_sch_192;
  logic [1919:0] k_sch_256;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_tb [256];

  localparam logic [127:0] PT_STD = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_inv_cipher_iter #(.Nk(4), .Nr(10)) u_aes128 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .k_sch(k_sch_128), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
  );

  aes_inv_cipher_iter #(.Nk(6), .Nr(12)) u_aes192 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .k_sch(k_sch_192), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
  );

  aes_inv_cipher_iter #(.Nk(8), .Nr(14)) u_aes256 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .k_sch(k_sch_256), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2])
  );

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box: multiplicative inverse followed by the affine transform.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
  endfunction

  // Key is left-aligned in 256 bits; round key r lands at [(nr-r)*128 +: 128].
  function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] ks;
    rc = 8'h01;
    ks = '0;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32 * i -: 32];
      end else begin
        t = w[i - 1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = gf_xtime(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i - nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) begin
      ks[(nr - r) * 128 +: 128] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    end
    return ks;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One complete block: offer, accept, count latency, check plaintext, handshake.
  task automatic applyStimulus(input int d, input logic [127:0] ct, input logic [127:0] pt,
                               input int nr, input string tag);
    int cnt;
    in_data[d]   = ct;
    in_valid[d]  = 1'b1;
    out_ready[d] = 1'b0;
    cnt = 0;
    while (!in_ready[d] && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkOutput({tag, " in_ready before accept"}, 128'(in_ready[d]), 128'd1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_data[d]  = ~ct;
    checkOutput({tag, " busy after accept"}, 128'(busy[d]), 128'd1);
    cnt = 0;
    while (!out_valid[d] && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkOutput({tag, " latency"}, 128'(cnt), 128'(nr));
    checkOutput({tag, " plaintext"}, out_data[d], pt);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    checkOutput({tag, " out_valid after handshake"}, 128'(out_valid[d]), 128'd0);
    checkOutput({tag, " in_ready after handshake"}, 128'(in_ready[d]), 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1919:0] ks;
    logic [127:0]  b2b_ct [3];
    logic [127:0]  b2b_pt [3];
    int            acc_cyc [3];
    int            n_acc, n_out, cyc, cnt, extra;
    logic          acc_now, hs_now;
    logic [127:0]  data_now;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      in_data[d]   = '0;
    end
    build_sbox();
    ks = expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    k_sch_128 = ks[1407:0];
    ks = expand_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    k_sch_192 = ks[1663:0];
    ks = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    k_sch_256 = ks;

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset in_ready[%0d]", d), 128'(in_ready[d]), 128'd1);
      checkOutput($sformatf("reset busy[%0d]", d), 128'(busy[d]), 128'd0);
      checkOutput($sformatf("reset out_valid[%0d]", d), 128'(out_valid[d]), 128'd0);
      checkOutput($sformatf("reset out_data[%0d]", d), out_data[d], 128'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] known-answer vectors");
    applyStimulus(0, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 10, "aes128");
    applyStimulus(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_STD, 12, "aes192");
    applyStimulus(2, CT_256, PT_STD, 14, "aes256");

    $display("[TB] back-pressure in DONE");
    in_data[2]  = CT_256;
    in_valid[2] = 1'b1;
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    cnt = 0;
    while (!out_valid[2] && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkOutput("bp latency", 128'(cnt), 128'd14);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp out_valid cyc%0d", i), 128'(out_valid[2]), 128'd1);
      checkOutput($sformatf("bp out_data cyc%0d", i), out_data[2], PT_STD);
      checkOutput($sformatf("bp in_ready cyc%0d", i), 128'(in_ready[2]), 128'd0);
    end
    out_ready[2] = 1'b1;
    @(posedge clk); #1;
    out_ready[2] = 1'b0;
    checkOutput("bp out_valid after handshake", 128'(out_valid[2]), 128'd0);
    checkOutput("bp in_ready after handshake", 128'(in_ready[2]), 128'd1);
    checkOutput("bp busy after handshake", 128'(busy[2]), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp single handshake", 128'(out_valid[2]), 128'd0);

    $display("[TB] reset mid-RUN");
    in_data[2]  = CT_256;
    in_valid[2] = 1'b1;
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("midrun busy before reset", 128'(busy[2]), 128'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrun out_valid", 128'(out_valid[2]), 128'd0);
    checkOutput("midrun out_data", out_data[2], 128'd0);
    checkOutput("midrun busy", 128'(busy[2]), 128'd0);
    checkOutput("midrun in_ready", 128'(in_ready[2]), 128'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(2, CT_256, PT_STD, 14, "post-reset aes256");

    $display("[TB] back-to-back aes128");
    b2b_ct[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    b2b_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    b2b_ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    b2b_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    b2b_ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
    b2b_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    out_ready[0] = 1'b1;
    in_data[0]   = b2b_ct[0];
    in_valid[0]  = 1'b1;
    n_acc = 0;
    n_out = 0;
    cyc   = 0;
    for (int i = 0; i < 3; i++) acc_cyc[i] = 0;
    while (n_out < 3 && cyc < 200) begin
      acc_now  = in_valid[0] && in_ready[0];
      hs_now   = out_valid[0] && out_ready[0];
      data_now = out_data[0];
      @(posedge clk); #1;
      cyc++;
      if (acc_now && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) in_data[0] = b2b_ct[n_acc];
        else in_valid[0] = 1'b0;
      end
      if (hs_now) begin
        checkOutput($sformatf("b2b out%0d", n_out), data_now, b2b_pt[n_out]);
        n_out++;
      end
    end
    checkOutput("b2b accepts", 128'(n_acc), 128'd3);
    checkOutput("b2b outputs", 128'(n_out), 128'd3);
    checkOutput("b2b spacing 0-1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
    checkOutput("b2b spacing 1-2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd12);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid[0]) extra++;
    end
    checkOutput("b2b no duplicate output", 128'(extra), 128'd0);
    out_ready[0] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
